seq_priority_encoder: RTL
=========================

// Module: seq_priority_encoder
// PURPOSE
//   Encoder counterpart to the team's 2-to-4 / 3-to-8 one-hot decoders. Captures an
//   8-bit multi-hot request vector and emits the 3-bit index of each set bit, one per
//   valid/ready transfer, in priority order.
//   Clearing each served bit is the inverse of decoder line expansion.
//   Sits between request sources (switches, decoder outputs) and a consumer that takes
//   one binary code at a time.
// PARAMETERS
//   WIDTH   8   number of request lines
//   IDX_W   3   code width; must equal clog2(WIDTH)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   en         in   1       global enable; 0 freezes all state and outputs
//   load       in   1       capture req when idle
//   req        in   WIDTH   request vector, sampled on accepted load
//   busy       out  1       1 while a captured vector is being drained
//   out_valid  out  1       out_code is valid
//   out_ready  in   1       consumer accepts out_code this cycle
//   out_code   out  IDX_W   index of the request bit being presented
//   done       out  1       one-cycle pulse: all captured bits delivered
// BEHAVIOUR
//   - Reset (rst=1 at posedge, any state, including mid-drain):
//     state=IDLE, pending=0, out_valid=0, out_code=0, done=0, busy=0, rr_ptr=WIDTH-1.
//   - rst has priority over en.
//   - States: IDLE, BUSY. busy = (state==BUSY).
//   - IDLE: on en & load, pending<=req and state<=BUSY. load is ignored in BUSY.
//   - BUSY: the slot is free when (!out_valid | out_ready). When en and the slot is free:
//       pending!=0 -> out_code<=sel, out_valid<=1, pending[sel]<=0
//       pending==0 -> out_valid<=0, done<=1 for one cycle, state<=IDLE
//   - When the slot is not free (out_valid & !out_ready): out_code, out_valid and
//     pending hold.
//   - Latency: load in cycle t -> first out_valid at t+2. Back-to-back codes each cycle
//     while out_ready=1. done occurs the cycle after the last code is accepted.
//   - req==0 on load: no out_valid. done pulses at t+2. Return to IDLE.
//   - done is 0 in every cycle not stated above.
//   - A load arriving in the same cycle as done is ignored. The state is still BUSY that
//     cycle.
//   - Fixed priority: sel = highest-index set bit of pending.
// CONFIGURATION
//   ROUND_ROBIN_EN defined:
//     - sel = first set bit of pending searching downward from rr_ptr, wrapping
//       0 -> WIDTH-1.
//     - After each code is issued, rr_ptr <= sel-1 mod WIDTH.
//     - rr_ptr persists across loads; it is cleared only by rst.
//   ROUND_ROBIN_EN undefined: fixed priority. No rr_ptr register exists.
// STRUCTURE
//   - Shared header enc_defs.vh: ENC_WIDTH=8, ENC_IDX_W=3, state encodings
//     ST_IDLE=1'b0, ST_BUSY=1'b1.
//   - Sub-module prio_pick8 (combinational): inputs vec[7:0], start[2:0]; outputs
//     idx[2:0], any.
//     - Returns the first set bit at or below start, with wrap.
//     - Fixed-priority mode ties start to 3'd7.
//   - Top level holds the FSM, the pending register, output registers and rr_ptr.
// TESTING
//   1. rst, then load req=8'b1010_0100 with out_ready=1:
//      -> out_code 7,5,2 on t+2..t+4; done at t+5; busy low at t+6.
//   2. Same load with out_ready=0 for 3 cycles after the first out_valid:
//      -> out_code=7 held stable with out_valid=1; then 5,2 follow; no code lost or
//      duplicated.
//   3. load req=8'h00 -> out_valid never 1; done pulses once at t+2.
//   4. During a drain of 8'hFF, assert load req=8'h01 -> ignored; exactly 8 codes 7..0,
//      then one done.
//   5. rst asserted after 2 codes of 8'hFF -> next cycle out_valid=0, busy=0, done=0.
//      A fresh load of 8'h10 yields only code 4.
//   6. en=0 for 2 cycles mid-drain -> all outputs frozen; resumes with no skipped
//      index.
//   7. ROUND_ROBIN_EN: load 8'h24 -> 5,2. Then load 8'h81:
//      -> fixed priority gives 7,0; round robin gives 0,7.

Source files
------------

// File: rtl/seq_priority_encoder_pkg.sv
// Shared widths and state encoding for the sequential priority encoder.
// Imported by prio_pick8 and seq_priority_encoder.
package seq_priority_encoder_pkg;

  localparam int ENC_WIDTH = 8;
  localparam int ENC_IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/seq_priority_encoder_prio_pick8.sv
// prio_pick8: first set bit of vec at or below start, wrapping 0 -> 7.
// Fixed-priority users tie start to 3'd7.
module prio_pick8
  import seq_priority_encoder_pkg::*;
(
  input  logic [ENC_WIDTH-1:0] vec,
  input  logic [ENC_IDX_W-1:0] start,
  output logic [ENC_IDX_W-1:0] idx,
  output logic                 any
);

  logic [ENC_IDX_W-1:0] j;

  // Walk from the farthest offset toward start so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
      j = start - ENC_IDX_W'(i);
      if (vec[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_priority_encoder.sv
// Drains a captured multi-hot vector as one index per valid/ready beat.
// Define ROUND_ROBIN_EN for a rotating search start instead of fixed priority.
module seq_priority_encoder
  import seq_priority_encoder_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  parameter int IDX_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_code,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             slot_free;
  logic             issue;

  assign busy      = (state == ST_BUSY);
  assign slot_free = !out_valid || out_ready;
  assign issue     = en && busy && !done && slot_free && any;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  assign start = rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= IDX_W'(WIDTH - 1);
    end else if (issue) begin
      rr_ptr <= sel - 1'b1;
    end
  end
`else
  assign start = IDX_W'(WIDTH - 1);
`endif

  prio_pick8 u_pick (
    .vec   (pending),
    .start (start),
    .idx   (sel),
    .any   (any)
  );

  // done holds BUSY for one extra cycle so a coincident load is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      done      <= 1'b0;
    end else if (en) begin
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            pending <= req;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end else if (slot_free) begin
            if (any) begin
              out_code     <= sel;
              out_valid    <= 1'b1;
              pending[sel] <= 1'b0;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
